// File: rtl/ooop_types.sv
// rtl/ooop_types.sv - shared out-of-order core widths and PRF read response type
package ooop_types;

  localparam int XLEN        = 32;
  localparam int PREG_W      = 6;
  localparam int N_PHYS_REGS = 64;
  localparam int ROB_W       = 5;
  localparam int RSP_ID_W    = 2;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    logic                valid;
    logic [RSP_ID_W-1:0] id;
    logic [ROB_W-1:0]    tag;
    xlen_t               rs1_data;
    xlen_t               rs2_data;
  } prf_rd_rsp_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the scan at ptr
module rr_pick #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = |req;
    idx        = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/prf_read_sched.sv
// rtl/prf_read_sched.sv - shares the PRF read ports among issue requesters, one per cycle
module prf_read_sched
  import ooop_types::*;
#(
  parameter int N_REQ = 3,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    recover_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*PREG_W-1:0] req_rs1_i,
  input  logic [N_REQ*PREG_W-1:0] req_rs2_i,
  input  logic [N_REQ*ROB_W-1:0]  req_tag_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_PHYS_REGS-1:0]  prf_valid_i,
  output logic [PREG_W-1:0]       prf_raddr1_o,
  output logic [PREG_W-1:0]       prf_raddr2_o,
  input  xlen_t                   prf_rdata1_i,
  input  xlen_t                   prf_rdata2_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IW-1:0]           rsp_id_o,
  output logic [ROB_W-1:0]        rsp_tag_o,
  output xlen_t                   rsp_rs1_data_o,
  output xlen_t                   rsp_rs2_data_o
);

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt_onehot;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             slot_free;
  logic             grant_en;
  logic [IW-1:0]    addr_sel;

  // Preg 0 is the hardwired zero register and is always ready.
  function automatic logic preg_ok(input logic [PREG_W-1:0] p, input logic [N_PHYS_REGS-1:0] v);
    return (p == '0) || v[p];
  endfunction

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_REQ; k++) begin
      eligible[k] = req_valid_i[k]
                    && preg_ok(req_rs1_i[k*PREG_W +: PREG_W], prf_valid_i)
                    && preg_ok(req_rs2_i[k*PREG_W +: PREG_W], prf_valid_i);
    end
  end

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req        (eligible),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign slot_free    = !rsp_valid_o || rsp_ready_i;
  assign grant_en     = slot_free && !flush_i && !recover_i && gnt_any;
  assign req_ready_o  = grant_en ? gnt_onehot : '0;
  assign addr_sel     = grant_en ? gnt_idx : rr_ptr;
  assign prf_raddr1_o = req_rs1_i[addr_sel*PREG_W +: PREG_W];
  assign prf_raddr2_o = req_rs2_i[addr_sel*PREG_W +: PREG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_id_o       <= '0;
      rsp_tag_o      <= '0;
      rsp_rs1_data_o <= '0;
      rsp_rs2_data_o <= '0;
    end else if (flush_i || recover_i) begin
      rsp_valid_o <= 1'b0;
    end else if (grant_en) begin
      rsp_valid_o    <= 1'b1;
      rsp_id_o       <= gnt_idx;
      rsp_tag_o      <= req_tag_i[gnt_idx*ROB_W +: ROB_W];
      rsp_rs1_data_o <= prf_rdata1_i;
      rsp_rs2_data_o <= prf_rdata2_i;
      rr_ptr         <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule
